// File: rtl/dmem_access_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl_if
//   Data-memory bus between the MEM-stage access sequencer and the memory.
//   Request channel is held stable while mem_req=1 and mem_gnt=0.
//   A single response (read data or write ack) follows each accepted request.
//
//   mem_req     master->slave  bus request, held until mem_gnt
//   mem_we      master->slave  1 = write
//   mem_addr    master->slave  word-aligned byte address
//   mem_wdata   master->slave  lane-replicated store data
//   mem_wstrb   master->slave  byte enables
//   mem_gnt     slave->master  request accepted this cycle
//   mem_rvalid  slave->master  response valid (read data or write ack)
//   mem_rdata   slave->master  read data
// -----------------------------------------------------------------------------
interface dmem_access_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_access_ctrl
//   MEM-stage data-memory access sequencer. Converts the EX/MEM load/store
//   request into a req/gnt + rvalid bus transaction, stalls the pipeline and
//   flushes MEM/WB while the access is outstanding, steers store lanes,
//   extends load data, flags misaligned accesses and aborts stuck accesses.
//
//   Parameters
//     TIMEOUT_CYCLES  max cycles spent in REQ+RESP before abort (1..65535)
//
//   Ports
//     clk             clock
//     rst_n           synchronous active-low reset
//     MemReadM        load in MEM stage (wins over MemWriteM)
//     MemWriteM       store in MEM stage
//     Funct3M         RV32I load/store funct3 (size/sign)
//     ALUResultM      byte address
//     WriteDataM      store data (rs2)
//     bus             data-memory bus (master side)
//     ReadDataM       registered, extended load data to MEM/WB
//     StallMem        hold F/D/E/M pipeline registers
//     FlushW          flush input of MEM/WB
//     misaligned_err  pulse while a misaligned access sits in IDLE
//     timeout_err     pulse during the DONE cycle that follows an abort
// -----------------------------------------------------------------------------
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 MemReadM,
    input  logic                 MemWriteM,
    input  logic [2:0]           Funct3M,
    input  logic [31:0]          ALUResultM,
    input  logic [31:0]          WriteDataM,
    dmem_access_ctrl_if.master   bus,
    output logic [31:0]          ReadDataM,
    output logic                 StallMem,
    output logic                 FlushW,
    output logic                 misaligned_err,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_t;

    // Counter value seen during the last permitted REQ/RESP cycle.
    localparam logic [15:0] LP_CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    // Registers
    state_t      r_state;
    logic [15:0] r_cnt;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic        r_abort;
    logic [31:0] r_rdata;

    // Combinational nets
    state_t      w_next;
    logic        w_access;
    logic        w_sz_byte;
    logic        w_sz_half;
    logic        w_misaligned;
    logic        w_start;
    logic        w_mis_access;
    logic        w_mis_load;
    logic        w_cnt_last;
    logic        w_abort;
    logic        w_capture;
    logic        w_busy;
    logic [31:0] w_wdata;
    logic [3:0]  w_wstrb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    assign w_access  = MemReadM | MemWriteM;
    assign w_sz_byte = (Funct3M[1:0] == 2'b00);
    assign w_sz_half = (Funct3M[1:0] == 2'b01);

    // Anything that is neither byte nor half is handled as a word access.
    assign w_misaligned = (w_sz_half & ALUResultM[0]) |
                          (~w_sz_byte & ~w_sz_half & (ALUResultM[1:0] != 2'b00));

    assign w_start      = (r_state == IDLE) & w_access & ~w_misaligned;
    assign w_mis_access = (r_state == IDLE) & w_access & w_misaligned;
    assign w_mis_load   = w_mis_access & MemReadM;
    assign w_cnt_last   = (r_cnt == LP_CNT_LAST);
    assign w_busy       = (r_state == REQ) | (r_state == RESP);

    // ------------------------------------------------------------------
    // Store lane steering (byte enables are left clear for loads)
    // ------------------------------------------------------------------
    always_comb begin
        w_wdata = WriteDataM;
        w_wstrb = 4'b1111;
        if (w_sz_byte) begin
            w_wdata = {4{WriteDataM[7:0]}};
            w_wstrb = 4'b0001 << ALUResultM[1:0];
        end else if (w_sz_half) begin
            w_wdata = {2{WriteDataM[15:0]}};
            w_wstrb = ALUResultM[1] ? 4'b1100 : 4'b0011;
        end
        if (MemReadM) begin
            w_wstrb = '0;
        end
    end

    // ------------------------------------------------------------------
    // Load lane select and extension, using the latched funct3/offset
    // ------------------------------------------------------------------
    always_comb begin
        w_byte = bus.mem_rdata[7:0];
        case (r_off)
            2'd1:    w_byte = bus.mem_rdata[15:8];
            2'd2:    w_byte = bus.mem_rdata[23:16];
            2'd3:    w_byte = bus.mem_rdata[31:24];
            default: w_byte = bus.mem_rdata[7:0];
        endcase
        w_half = r_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (r_f3[1:0])
            2'b00:   w_ext = {{24{w_byte[7] & ~r_f3[2]}}, w_byte};
            2'b01:   w_ext = {{16{w_half[15] & ~r_f3[2]}}, w_half};
            default: w_ext = bus.mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next state
    //   REQ : a timeout in the same cycle as gnt still aborts.
    //   RESP: a response arriving in the last permitted cycle completes.
    // ------------------------------------------------------------------
    always_comb begin
        w_next    = r_state;
        w_abort   = 1'b0;
        w_capture = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = REQ;
                end
            end
            REQ: begin
                if (w_cnt_last) begin
                    w_next  = DONE;
                    w_abort = 1'b1;
                end else if (bus.mem_gnt) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                if (bus.mem_rvalid) begin
                    w_next    = DONE;
                    w_capture = ~r_we;
                end else if (w_cnt_last) begin
                    w_next  = DONE;
                    w_abort = 1'b1;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_off   <= '0;
            r_abort <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_abort <= w_abort;

            if (w_start) begin
                r_addr  <= {ALUResultM[31:2], 2'b00};
                r_wdata <= w_wdata;
                r_wstrb <= w_wstrb;
                r_we    <= MemWriteM & ~MemReadM;
                r_f3    <= Funct3M;
                r_off   <= ALUResultM[1:0];
                r_cnt   <= '0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (w_capture) begin
                r_rdata <= w_ext;
            end else if (w_abort | w_mis_load) begin
                r_rdata <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.mem_req   = (r_state == REQ);
    assign bus.mem_we    = r_we;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_wstrb = r_wstrb;

    assign ReadDataM = r_rdata;

    // Pipeline controls and error pulses are suppressed while reset is held,
    // even though the state register only clears on the next edge.
    assign StallMem       = rst_n & (w_start | w_busy);
    assign FlushW         = rst_n & (w_start | w_busy | w_mis_access |
                                     ((r_state == DONE) & r_abort));
    assign misaligned_err = rst_n & w_mis_access;
    assign timeout_err    = rst_n & (r_state == DONE) & r_abort;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_access_ctrl
//   Directed bench for dmem_access_ctrl. Each access is described at the
//   transaction level (op, funct3, address, data, gnt delay, rvalid delay);
//   the expected cycle timeline and data are derived arithmetically and a
//   single negedge compare process checks the DUT every cycle.
// -----------------------------------------------------------------------------
module tb_dmem_access_ctrl;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallMem;
    logic        FlushW;
    logic        misaligned_err;
    logic        timeout_err;

    dmem_access_ctrl_if bus_if ();

    dmem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .MemReadM       (MemReadM),
        .MemWriteM      (MemWriteM),
        .Funct3M        (Funct3M),
        .ALUResultM     (ALUResultM),
        .WriteDataM     (WriteDataM),
        .bus            (bus_if),
        .ReadDataM      (ReadDataM),
        .StallMem       (StallMem),
        .FlushW         (FlushW),
        .misaligned_err (misaligned_err),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    int n_err   = 0;
    int n_chk   = 0;
    int n_stall = 0;

    // Per-cycle expectations
    logic        e_chk = 1'b0;
    logic        e_stall, e_flush, e_mis, e_to, e_req, e_pay, e_we;
    logic [31:0] e_rd, e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic [31:0] m_rd;   // model of the load-data register

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (e_chk) begin
            chk("StallMem", {31'd0, StallMem}, {31'd0, e_stall});
            chk("FlushW", {31'd0, FlushW}, {31'd0, e_flush});
            chk("misaligned_err", {31'd0, misaligned_err}, {31'd0, e_mis});
            chk("timeout_err", {31'd0, timeout_err}, {31'd0, e_to});
            chk("mem_req", {31'd0, bus_if.mem_req}, {31'd0, e_req});
            chk("ReadDataM", ReadDataM, e_rd);
            if (e_pay) begin
                chk("mem_addr", bus_if.mem_addr, e_addr);
                chk("mem_we", {31'd0, bus_if.mem_we}, {31'd0, e_we});
                if (e_we) begin
                    chk("mem_wdata", bus_if.mem_wdata, e_wdata);
                    chk("mem_wstrb", {28'd0, bus_if.mem_wstrb}, {28'd0, e_wstrb});
                end
            end
        end
        if (StallMem) n_stall++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input logic rv, input logic [31:0] rdat);
        for (int i = 0; i < n; i++) begin
            MemReadM = 1'b0; MemWriteM = 1'b0;
            bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = rv; bus_if.mem_rdata = rdat;
            e_stall = 0; e_flush = 0; e_mis = 0; e_to = 0; e_req = 0; e_pay = 0;
            e_rd = m_rd;
            step();
        end
        bus_if.mem_rvalid = 1'b0;
    endtask

    // gnt_wait: REQ cycles before gnt (-1 = never); rv_wait: cycles after gnt
    // until rvalid (-1 = never).
    task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input int gnt_wait, input int rv_wait, input logic [31:0] rdat);
        int          size, reqc, respc;
        bit          mis, abort;
        int unsigned sh;
        logic [31:0] ext, fin;

        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        mis  = (addr % size) != 0;
        sh   = 8 * (addr % 4);
        ext  = rdat >> sh;
        if (size == 1) begin
            ext = ext & 32'hFF;
            if (!f3[2] && ext >= 32'd128) ext = ext - 32'd256;
        end else if (size == 2) begin
            ext = ext & 32'hFFFF;
            if (!f3[2] && ext >= 32'd32768) ext = ext - 32'd65536;
        end

        abort = 0; respc = 0;
        if (gnt_wait < 0 || gnt_wait + 1 >= TMO) begin
            abort = 1; reqc = TMO;
        end else begin
            reqc = gnt_wait + 1;
            if (rv_wait >= 1 && rv_wait <= TMO - reqc) respc = rv_wait;
            else begin abort = 1; respc = TMO - reqc; end
        end

        e_addr  = addr & 32'hFFFF_FFFC;
        e_we    = wr && !rd;
        e_wdata = (size == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                  (size == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
        e_wstrb = 4'(((1 << size) - 1) << (addr % 4));

        // IDLE with the request presented
        MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
        bus_if.mem_gnt = 1'b0; bus_if.mem_rvalid = 1'b0;
        e_pay = 0; e_req = 0; e_to = 0; e_rd = m_rd;
        e_mis = mis; e_flush = 1; e_stall = !mis;
        step();
        if (mis) begin
            if (rd) m_rd = '0;
            return;
        end

        for (int i = 0; i < reqc; i++) begin
            bus_if.mem_gnt = (gnt_wait >= 0 && i == gnt_wait);
            e_req = 1; e_pay = 1; e_stall = 1; e_flush = 1; e_mis = 0; e_to = 0; e_rd = m_rd;
            step();
        end
        bus_if.mem_gnt = 1'b0;

        for (int j = 1; j <= respc; j++) begin
            bus_if.mem_rvalid = (j == rv_wait);
            bus_if.mem_rdata  = (j == rv_wait) ? rdat : 32'h5A5A_5A5A;
            e_req = 0; e_pay = 0; e_stall = 1; e_flush = 1; e_rd = m_rd;
            step();
        end
        bus_if.mem_rvalid = 1'b0;

        if (abort) fin = '0;
        else if (rd) fin = ext;
        else fin = m_rd;
        e_req = 0; e_pay = 0; e_stall = 0; e_flush = abort; e_to = abort; e_rd = fin;
        step();
        m_rd = fin;
    endtask

    initial begin
        rst_n = 1'b0; MemReadM = 0; MemWriteM = 0; Funct3M = '0; ALUResultM = '0; WriteDataM = '0;
        bus_if.mem_gnt = 0; bus_if.mem_rvalid = 0; bus_if.mem_rdata = '0;
        m_rd = '0;
        step();

        // Reset held with a misaligned load presented: controls stay low
        e_chk = 1; e_stall = 0; e_flush = 0; e_mis = 0; e_to = 0; e_req = 0; e_pay = 0; e_rd = '0;
        MemReadM = 1; Funct3M = 3'b010; ALUResultM = 32'h102;
        step();
        chk("rst_mem_addr", bus_if.mem_addr, 32'h0);
        chk("rst_mem_wdata", bus_if.mem_wdata, 32'h0);
        chk("rst_mem_wstrb", {28'd0, bus_if.mem_wstrb}, 32'h0);
        chk("rst_mem_we", {31'd0, bus_if.mem_we}, 32'h0);
        rst_n = 1'b1;
        idle(1, 1'b0, '0);

        // LW best case
        n_stall = 0;
        run_access(1, 0, 3'b010, 32'h100, 0, 0, 1, 32'h8000_00F0);
        chk("lw_stall_cycles", n_stall, 3);
        chk("lw_rdata", ReadDataM, 32'h8000_00F0);

        // Load extension, back to back
        run_access(1, 0, 3'b000, 32'h103, 0, 0, 1, 32'h8012_3456);
        chk("lb_103", ReadDataM, 32'hFFFF_FF80);
        run_access(1, 0, 3'b100, 32'h103, 0, 0, 1, 32'h8012_3456);
        chk("lbu_103", ReadDataM, 32'h0000_0080);
        run_access(1, 0, 3'b101, 32'h102, 0, 0, 1, 32'h8012_3456);
        chk("lhu_102", ReadDataM, 32'h0000_8012);
        run_access(1, 0, 3'b001, 32'h102, 0, 1, 2, 32'h8012_3456);
        chk("lh_102", ReadDataM, 32'hFFFF_8012);
        run_access(1, 0, 3'b000, 32'h101, 0, 0, 1, 32'h8012_3456);
        run_access(1, 0, 3'b001, 32'h100, 0, 0, 1, 32'h8012_3456);
        chk("lh_100", ReadDataM, 32'h0000_3456);

        // Stores
        run_access(0, 1, 3'b000, 32'h201, 32'h0000_00AB, 0, 1, '0);
        chk("sb_wstrb", {28'd0, bus_if.mem_wstrb}, 32'h2);
        chk("sb_wdata", bus_if.mem_wdata, 32'hABAB_ABAB);
        chk("sb_we", {31'd0, bus_if.mem_we}, 32'h1);
        run_access(0, 1, 3'b001, 32'h202, 32'h0000_1234, 2, 1, '0);
        chk("sh_wstrb", {28'd0, bus_if.mem_wstrb}, 32'hC);
        run_access(0, 1, 3'b010, 32'h204, 32'hCAFE_F00D, 0, 3, '0);
        chk("store_keeps_rdata", ReadDataM, 32'h0000_3456);

        // Misaligned accesses
        run_access(0, 1, 3'b001, 32'h201, 32'h5555, 0, 1, '0);
        run_access(1, 0, 3'b010, 32'h102, 0, 0, 1, '0);
        idle(1, 1'b0, '0);
        chk("mis_lw_rdata", ReadDataM, 32'h0);
        run_access(1, 0, 3'b101, 32'h103, 0, 0, 1, '0);

        // Withheld grant, then abort with no grant and a late response
        run_access(1, 0, 3'b010, 32'h40C, 0, 4, 2, 32'h1122_3344);
        chk("gnt_wait_rdata", ReadDataM, 32'h1122_3344);
        run_access(0, 1, 3'b010, 32'h500, 32'h99, -1, 1, '0);
        idle(1, 1'b1, 32'h7777_7777);
        idle(1, 1'b0, '0);
        chk("late_rvalid_dropped", ReadDataM, 32'h0);

        // Response-phase timeout and response on the last permitted cycle
        run_access(1, 0, 3'b010, 32'h604, 0, 0, 1, 32'hA5A5_A5A5);
        run_access(1, 0, 3'b010, 32'h600, 0, 0, -1, '0);
        run_access(1, 0, 3'b010, 32'h608, 0, 0, TMO - 1, 32'h0BAD_F00D);
        chk("last_cycle_rvalid", ReadDataM, 32'h0BAD_F00D);

        // Read wins over write; unsupported funct3 treated as word
        run_access(1, 1, 3'b010, 32'h700, 32'hFFFF_FFFF, 1, 1, 32'h1357_9BDF);
        chk("rw_we", {31'd0, bus_if.mem_we}, 32'h0);
        run_access(1, 0, 3'b011, 32'h104, 0, 0, 1, 32'h2468_ACE0);
        chk("f3_011_word", ReadDataM, 32'h2468_ACE0);
        run_access(1, 0, 3'b110, 32'h106, 0, 0, 1, '0);

        // Reset during RESP
        MemReadM = 1; MemWriteM = 0; Funct3M = 3'b010; ALUResultM = 32'h300;
        e_stall = 1; e_flush = 1; e_mis = 0; e_to = 0; e_req = 0; e_pay = 0; e_rd = m_rd;
        step();
        bus_if.mem_gnt = 1; e_req = 1;
        step();
        bus_if.mem_gnt = 0;
        rst_n = 1'b0; e_stall = 0; e_flush = 0; e_req = 0;
        step();
        m_rd = '0;
        rst_n = 1'b1;
        idle(1, 1'b1, 32'hDEAD_BEEF);
        idle(1, 1'b0, '0);
        chk("rst_mid_rdata", ReadDataM, 32'h0);
        chk("rst_mid_req", {31'd0, bus_if.mem_req}, 32'h0);

        e_chk = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
